time_set_ctrl: RTL and testbench

Time-setting controller for the clock design. It consumes the one-cycle button pulses from the chatter-removal stage and the 1 Hz timebase tick. It sequences the clock through normal run and hour/minute/second edit modes. Outputs are increment/clear strobes, a run enable for the timekeeping counters, and a per-field blink mask for the 7-seg display driver.

---
 rtl/time_set_ctrl.sv | 166 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl -- time-setting controller for the clock design.
//
// Walks the clock through NORMAL run and the hour/minute/second edit
// states using one-cycle button pulses, issues one-cycle increment/clear
// strobes to the timekeeping counters and produces a per-field blink
// mask for the 7-seg driver.
//
// Optional feature macro: TIME_SET_AUTO_RETURN_EN
//   defined   : an inactivity timeout (TIMEOUT_S EN1HZ ticks) drops an
//               edit state back to NORMAL.
//   undefined : no timeout counter; edit states persist until MODE.
module time_set_ctrl #(
  parameter int BLINK_DIV = 12500000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BTN,
  input  logic       EN1HZ,
  output logic       RUN_EN,
  output logic       MODE_SET,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       CLR_SEC,
  output logic [2:0] BLINK_SEL,
  output logic [1:0] STATE
);

  // Blink counter must hold 0..BLINK_DIV-1; keep at least one bit so a
  // degenerate divider still elaborates.
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } stateT;

  stateT         state;
  stateT         nextState;
  logic          upAccepted;
  logic          btnAccepted;
  logic [BW-1:0] blinkCnt;
  logic          blinkPhase;
  logic          incHour;
  logic          incMin;
  logic          clrSec;

  // Button priority MODE > SELECT > UP: lower-priority bits are dropped.
  logic modeHit;
  logic selHit;
  logic upHit;
  assign modeHit = BTN[0];
  assign selHit  = !BTN[0] && BTN[1];
  assign upHit   = !BTN[0] && !BTN[1] && BTN[2];

`ifdef TIME_SET_AUTO_RETURN_EN
  localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);

  logic [TW-1:0] timeoutCnt;
  logic          timeoutHit;

  // Inactivity expires when a tick would bring the counter to TIMEOUT_S
  // and no button is being acted on in the same cycle (button wins).
  assign timeoutHit = (state != NORMAL) && !btnAccepted && EN1HZ &&
                      (timeoutCnt == TIMEOUT_LAST);
`else
  logic unusedTick;
  assign unusedTick = EN1HZ;
`endif

  // Next-state decode and classification of the accepted button action.
  always_comb begin
    nextState   = state;
    upAccepted  = 1'b0;
    btnAccepted = 1'b0;
    case (state)
      NORMAL: begin
        if (modeHit) begin
          nextState   = SET_HOUR;
          btnAccepted = 1'b1;
        end
      end
      default: begin
        btnAccepted = modeHit || selHit || upHit;
        if (modeHit) begin
          nextState = NORMAL;
        end else if (selHit) begin
          case (state)
            SET_HOUR: nextState = SET_MIN;
            SET_MIN:  nextState = SET_SEC;
            default:  nextState = SET_HOUR;
          endcase
        end else if (upHit) begin
          upAccepted = 1'b1;
        end
`ifdef TIME_SET_AUTO_RETURN_EN
        if (timeoutHit) begin
          nextState = NORMAL;
        end
`endif
      end
    endcase
  end

  // State register, registered strobes and blink timing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= NORMAL;
      incHour    <= 1'b0;
      incMin     <= 1'b0;
      clrSec     <= 1'b0;
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else begin
      state   <= nextState;
      incHour <= upAccepted && (state == SET_HOUR);
      incMin  <= upAccepted && (state == SET_MIN);
      clrSec  <= upAccepted && (state == SET_SEC);
      if ((nextState != state) || upAccepted) begin
        blinkCnt   <= '0;
        blinkPhase <= 1'b0;
      end else if (blinkCnt == BLINK_LAST) begin
        blinkCnt   <= '0;
        blinkPhase <= !blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

`ifdef TIME_SET_AUTO_RETURN_EN
  // Inactivity counter: runs on EN1HZ only while editing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timeoutCnt <= '0;
    end else if ((state == NORMAL) || btnAccepted || timeoutHit) begin
      timeoutCnt <= '0;
    end else if (EN1HZ) begin
      timeoutCnt <= timeoutCnt + 1'b1;
    end
  end
`endif

  // Output decode straight from registers.
  always_comb begin
    BLINK_SEL = 3'b000;
    case (state)
      SET_HOUR: BLINK_SEL = {blinkPhase, 2'b00};
      SET_MIN:  BLINK_SEL = {1'b0, blinkPhase, 1'b0};
      SET_SEC:  BLINK_SEL = {2'b00, blinkPhase};
      default:  BLINK_SEL = 3'b000;
    endcase
  end

  assign RUN_EN   = (state == NORMAL);
  assign MODE_SET = (state != NORMAL);
  assign INC_HOUR = incHour;
  assign INC_MIN  = incMin;
  assign CLR_SEC  = clrSec;
  assign STATE    = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl -- directed self-checking bench for time_set_ctrl.
// Build with TIME_SET_AUTO_RETURN_EN defined to exercise the timeout.
module tb_time_set_ctrl;

  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_SEL  = 3'b010;
  localparam logic [2:0] B_UP   = 3'b100;

  logic       CLK;
  logic       RST;
  logic [2:0] BTN;
  logic       EN1HZ;
  logic       RUN_EN;
  logic       MODE_SET;
  logic       INC_HOUR;
  logic       INC_MIN;
  logic       CLR_SEC;
  logic [2:0] BLINK_SEL;
  logic [1:0] STATE;

  int compares = 0;
  int fails    = 0;

  time_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_S(3)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .EN1HZ(EN1HZ),
    .RUN_EN(RUN_EN), .MODE_SET(MODE_SET), .INC_HOUR(INC_HOUR),
    .INC_MIN(INC_MIN), .CLR_SEC(CLR_SEC), .BLINK_SEL(BLINK_SEL),
    .STATE(STATE)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive inputs for one rising edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic [2:0] b, input logic t);
    BTN   = b;
    EN1HZ = t;
    @(posedge CLK);
    #1;
    BTN   = 3'b000;
    EN1HZ = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(B_MODE, 1'b0);
    BTN = B_UP;
    @(posedge CLK);
    #2;
    BTN = 3'b000;
    RST = 1'b1;
    #1;
    compares++;
    if (STATE !== 2'd0) begin fails++; $display("[TB] FAIL reset_state got %0d want 0", STATE); end
    compares++;
    if (RUN_EN !== 1'b1 || MODE_SET !== 1'b0) begin fails++; $display("[TB] FAIL reset_run got %b/%b want 1/0", RUN_EN, MODE_SET); end
    compares++;
    if (BLINK_SEL !== 3'b000) begin fails++; $display("[TB] FAIL reset_blink got %b want 000", BLINK_SEL); end
    compares++;
    if ({INC_HOUR, INC_MIN, CLR_SEC} !== 3'b000) begin fails++; $display("[TB] FAIL reset_strobes got %b want 000", {INC_HOUR, INC_MIN, CLR_SEC}); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus(3'b000, 1'b0);
    compares++;
    if ({INC_HOUR, STATE} !== 3'b000) begin fails++; $display("[TB] FAIL reset_dropped got %b want 000", {INC_HOUR, STATE}); end
  endtask

  task automatic test_mode_select();
    applyStimulus(B_SEL, 1'b0);
    compares++;
    if (STATE !== 2'd0) begin fails++; $display("[TB] FAIL normal_select got %0d want 0", STATE); end
    applyStimulus(B_UP, 1'b0);
    compares++;
    if ({INC_HOUR, INC_MIN, CLR_SEC} !== 3'b000) begin fails++; $display("[TB] FAIL normal_up got %b want 000", {INC_HOUR, INC_MIN, CLR_SEC}); end
    applyStimulus(B_MODE, 1'b0);
    compares++;
    if (STATE !== 2'd1 || RUN_EN !== 1'b0 || MODE_SET !== 1'b1) begin fails++; $display("[TB] FAIL mode_enter got %0d/%b/%b want 1/0/1", STATE, RUN_EN, MODE_SET); end
    applyStimulus(B_SEL, 1'b0);
    compares++;
    if (STATE !== 2'd2) begin fails++; $display("[TB] FAIL select1 got %0d want 2", STATE); end
    applyStimulus(B_SEL, 1'b0);
    compares++;
    if (STATE !== 2'd3) begin fails++; $display("[TB] FAIL select2 got %0d want 3", STATE); end
    applyStimulus(B_SEL, 1'b0);
    compares++;
    if (STATE !== 2'd1) begin fails++; $display("[TB] FAIL select3 got %0d want 1", STATE); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(B_UP, 1'b0);
    compares++;
    if ({INC_HOUR, INC_MIN, CLR_SEC} !== 3'b100) begin fails++; $display("[TB] FAIL inc_hour1 got %b want 100", {INC_HOUR, INC_MIN, CLR_SEC}); end
    applyStimulus(B_UP, 1'b0);
    compares++;
    if ({INC_HOUR, INC_MIN, CLR_SEC} !== 3'b100) begin fails++; $display("[TB] FAIL inc_hour2 got %b want 100", {INC_HOUR, INC_MIN, CLR_SEC}); end
    applyStimulus(3'b000, 1'b0);
    compares++;
    if (INC_HOUR !== 1'b0) begin fails++; $display("[TB] FAIL inc_hour_end got %b want 0", INC_HOUR); end
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(B_UP, 1'b0);
    compares++;
    if ({STATE, INC_HOUR, INC_MIN, CLR_SEC} !== 5'b11001) begin fails++; $display("[TB] FAIL clr_sec got %b want 11001", {STATE, INC_HOUR, INC_MIN, CLR_SEC}); end
    applyStimulus(3'b000, 1'b0);
    compares++;
    if (CLR_SEC !== 1'b0) begin fails++; $display("[TB] FAIL clr_sec_end got %b want 0", CLR_SEC); end
  endtask

  task automatic test_priority();
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(3'b111, 1'b0);
    compares++;
    if (STATE !== 2'd0 || INC_MIN !== 1'b0) begin fails++; $display("[TB] FAIL prio_111 got %0d/%b want 0/0", STATE, INC_MIN); end
    applyStimulus(3'b000, 1'b0);
    compares++;
    if (INC_MIN !== 1'b0) begin fails++; $display("[TB] FAIL prio_111_late got %b want 0", INC_MIN); end
    applyStimulus(B_MODE, 1'b0);
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(3'b110, 1'b0);
    compares++;
    if ({STATE, INC_HOUR, INC_MIN, CLR_SEC} !== 5'b11000) begin fails++; $display("[TB] FAIL prio_110 got %b want 11000", {STATE, INC_HOUR, INC_MIN, CLR_SEC}); end
  endtask

  task automatic test_blink();
    applyStimulus(B_SEL, 1'b0);
    applyStimulus(B_SEL, 1'b0);
    compares++;
    if (STATE !== 2'd2 || BLINK_SEL !== 3'b000) begin fails++; $display("[TB] FAIL blink_enter got %0d/%b want 2/000", STATE, BLINK_SEL); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 1'b0);
      compares++;
      if (BLINK_SEL !== 3'b000) begin fails++; $display("[TB] FAIL blink_vis%0d got %b want 000", i, BLINK_SEL); end
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b000, 1'b0);
      compares++;
      if (BLINK_SEL !== 3'b010) begin fails++; $display("[TB] FAIL blink_blank%0d got %b want 010", i, BLINK_SEL); end
    end
    applyStimulus(3'b000, 1'b0);
    compares++;
    if (BLINK_SEL !== 3'b000) begin fails++; $display("[TB] FAIL blink_wrap got %b want 000", BLINK_SEL); end
    for (int i = 0; i < 5; i++) applyStimulus(3'b000, 1'b0);
    applyStimulus(B_UP, 1'b0);
    compares++;
    if (BLINK_SEL !== 3'b000 || INC_MIN !== 1'b1) begin fails++; $display("[TB] FAIL blink_up got %b/%b want 000/1", BLINK_SEL, INC_MIN); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 1'b0);
      compares++;
      if (BLINK_SEL !== 3'b000) begin fails++; $display("[TB] FAIL blink_restart%0d got %b want 000", i, BLINK_SEL); end
    end
    applyStimulus(3'b000, 1'b0);
    compares++;
    if (BLINK_SEL !== 3'b010) begin fails++; $display("[TB] FAIL blink_reblank got %b want 010", BLINK_SEL); end
  endtask

  task automatic test_timeout();
    applyStimulus(B_MODE, 1'b0);
    applyStimulus(B_MODE, 1'b0);
`ifdef TIME_SET_AUTO_RETURN_EN
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'b000, 1'b1);
      compares++;
      if (STATE !== 2'd1) begin fails++; $display("[TB] FAIL timeout_wait%0d got %0d want 1", i, STATE); end
    end
    applyStimulus(3'b000, 1'b1);
    compares++;
    if (STATE !== 2'd0) begin fails++; $display("[TB] FAIL timeout_fire got %0d want 0", STATE); end
    applyStimulus(B_MODE, 1'b0);
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b000, 1'b1);
    applyStimulus(B_SEL, 1'b1);
    compares++;
    if (STATE !== 2'd2) begin fails++; $display("[TB] FAIL timeout_btn_wins got %0d want 2", STATE); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'b000, 1'b1);
      compares++;
      if (STATE !== 2'd2) begin fails++; $display("[TB] FAIL timeout_restart%0d got %0d want 2", i, STATE); end
    end
    applyStimulus(3'b000, 1'b1);
    compares++;
    if (STATE !== 2'd0) begin fails++; $display("[TB] FAIL timeout_refire got %0d want 0", STATE); end
`else
    for (int i = 0; i < 100; i++) applyStimulus(3'b000, 1'b1);
    compares++;
    if (STATE !== 2'd1) begin fails++; $display("[TB] FAIL no_timeout got %0d want 1", STATE); end
`endif
  endtask

  initial begin
    RST   = 1'b1;
    BTN   = 3'b000;
    EN1HZ = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    test_reset();
    test_mode_select();
    test_back_to_back();
    test_priority();
    test_blink();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
